// File: rtl/asynchronous_fifo_read_port.sv
// rtl/asynchronous_fifo_read_port.sv - read-domain controller of the dual-clock FIFO
// Synchronises the write pointer, fetches from a sync-read RAM, presents standard or FWFT data.
module asynchronous_fifo_read_port #(
  parameter int DATA_WIDTH              = 16,
  parameter int DATA_DEPTH              = 4096,
  parameter int SYNC_STAGES             = 2,
  parameter int FIRST_WORD_FALL_THROUGH = 1,
  parameter int ALMOST_EMPTY_THRESHOLD  = 4,
  localparam int AW = $clog2(DATA_DEPTH),
  localparam int PW = AW + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  read_enable,
  input  logic [PW-1:0]         write_pointer_gray,
  input  logic [DATA_WIDTH-1:0] memory_read_data,
  output logic [AW-1:0]         memory_read_address,
  output logic                  memory_read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_data_valid,
  output logic [PW-1:0]         read_pointer_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [PW-1:0]         read_count,
  output logic                  underflow
);

  localparam logic          FWFT      = (FIRST_WORD_FALL_THROUGH != 0);
  localparam logic [PW:0]   DEPTH_W   = (PW+1)'(DATA_DEPTH);
  localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESHOLD);

  function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         wptr_sync;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         rptr_gray_q, rptr_gray_d;
  logic                  mem_empty_q, mem_empty_d;
  logic                  in_flight_q, in_flight_d;
  logic                  head_valid_q, head_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  underflow_q, underflow_d;

  logic                  pop;
  logic                  fetch;
  logic [1:0]            occupancy;
  logic [1:0]            buffered_words;
  logic [PW-1:0]         mem_words;
  logic [PW:0]           total_words;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= write_pointer_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wptr_sync = gray_to_bin(sync_q[SYNC_STAGES-1]);

  // Buffer + in-flight never exceeds 2, so a fetch is only issued when room is guaranteed.
  assign occupancy = {1'b0, head_valid_q} + {1'b0, skid_valid_q} + {1'b0, in_flight_q};
  assign pop       = FWFT && read_enable && head_valid_q;

  always_comb begin
    fetch = 1'b0;
    if (reset_n && !mem_empty_q) begin
      if (FWFT) fetch = (occupancy < (pop ? 2'd3 : 2'd2));
      else      fetch = read_enable;
    end
  end

  always_comb begin
    rptr_d       = rptr_q + {{AW{1'b0}}, fetch};
    rptr_gray_d  = rptr_d ^ (rptr_d >> 1);
    mem_empty_d  = (wptr_sync == rptr_d);
    in_flight_d  = fetch;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    read_data_d  = read_data_q;
    skid_data_d  = skid_data_q;
    if (FWFT) begin
      if (pop) begin
        if (skid_valid_q) begin
          read_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else begin
          head_valid_d = 1'b0;
        end
      end
      if (in_flight_q) begin
        if (!head_valid_d) begin
          head_valid_d = 1'b1;
          read_data_d  = memory_read_data;
        end else begin
          skid_valid_d = 1'b1;
          skid_data_d  = memory_read_data;
        end
      end
    end else begin
      head_valid_d = in_flight_q;
      skid_valid_d = 1'b0;
      if (in_flight_q) read_data_d = memory_read_data;
    end
  end

  // Words already fetched still belong to the user until popped; clamp covers the
  // window where the writer has reused slots whose words sit in the output buffer.
  always_comb begin
    mem_words      = wptr_sync - rptr_d;
    buffered_words = 2'd0;
    if (FWFT) buffered_words = {1'b0, head_valid_d} + {1'b0, skid_valid_d} + {1'b0, in_flight_d};
    total_words    = {1'b0, mem_words} + {{(PW-1){1'b0}}, buffered_words};
    if (total_words > DEPTH_W) total_words = DEPTH_W;
    count_d        = total_words[PW-1:0];
    almost_empty_d = (count_d <= AE_THRESH);
    underflow_d    = read_enable && (FWFT ? !head_valid_q : mem_empty_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rptr_q         <= '0;
      rptr_gray_q    <= '0;
      mem_empty_q    <= 1'b1;
      in_flight_q    <= 1'b0;
      head_valid_q   <= 1'b0;
      skid_valid_q   <= 1'b0;
      read_data_q    <= '0;
      skid_data_q    <= '0;
      count_q        <= '0;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      rptr_q         <= rptr_d;
      rptr_gray_q    <= rptr_gray_d;
      mem_empty_q    <= mem_empty_d;
      in_flight_q    <= in_flight_d;
      head_valid_q   <= head_valid_d;
      skid_valid_q   <= skid_valid_d;
      read_data_q    <= read_data_d;
      skid_data_q    <= skid_data_d;
      count_q        <= count_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
    end
  end

  assign memory_read_address = rptr_q[AW-1:0];
  assign memory_read_enable  = fetch;
  assign read_data           = read_data_q;
  assign read_data_valid     = head_valid_q;
  assign read_pointer_gray   = rptr_gray_q;
  assign empty               = FWFT ? !head_valid_q : mem_empty_q;
  assign almost_empty        = almost_empty_q;
  assign read_count          = count_q;
  assign underflow           = underflow_q;

endmodule

// File: tb/tb_asynchronous_fifo_read_port.sv
// tb/tb_asynchronous_fifo_read_port.sv - directed bench for standard and FWFT read ports
module tb_asynchronous_fifo_read_port;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic [4:0]  wp_s = '0, wp_f = '0;
  logic        re_s = 1'b0, re_f = 1'b0;
  logic [15:0] mem_s [16];
  logic [15:0] mem_f [16];
  logic [15:0] s_mrd = '0, f_mrd = '0;

  logic [4:0]  s_wgray, f_wgray;
  logic [3:0]  s_addr, f_addr;
  logic        s_mre, f_mre;
  logic [15:0] s_data, f_data;
  logic        s_valid, f_valid, s_empty, f_empty, s_ae, f_ae, s_uf, f_uf;
  logic [4:0]  s_gray, f_gray, s_count, f_count;

  assign s_wgray = wp_s ^ (wp_s >> 1);
  assign f_wgray = wp_f ^ (wp_f >> 1);

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (s_mre) s_mrd <= mem_s[s_addr];
    if (f_mre) f_mrd <= mem_f[f_addr];
  end

  asynchronous_fifo_read_port #(
    .DATA_WIDTH(16), .DATA_DEPTH(16), .SYNC_STAGES(2),
    .FIRST_WORD_FALL_THROUGH(0), .ALMOST_EMPTY_THRESHOLD(4)
  ) u_std (
    .clock(clock), .reset_n(reset_n), .read_enable(re_s),
    .write_pointer_gray(s_wgray), .memory_read_data(s_mrd),
    .memory_read_address(s_addr), .memory_read_enable(s_mre),
    .read_data(s_data), .read_data_valid(s_valid), .read_pointer_gray(s_gray),
    .empty(s_empty), .almost_empty(s_ae), .read_count(s_count), .underflow(s_uf)
  );

  asynchronous_fifo_read_port #(
    .DATA_WIDTH(16), .DATA_DEPTH(16), .SYNC_STAGES(2),
    .FIRST_WORD_FALL_THROUGH(1), .ALMOST_EMPTY_THRESHOLD(4)
  ) u_fwft (
    .clock(clock), .reset_n(reset_n), .read_enable(re_f),
    .write_pointer_gray(f_wgray), .memory_read_data(f_mrd),
    .memory_read_address(f_addr), .memory_read_enable(f_mre),
    .read_data(f_data), .read_data_valid(f_valid), .read_pointer_gray(f_gray),
    .empty(f_empty), .almost_empty(f_ae), .read_count(f_count), .underflow(f_uf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_s_data", 32'(s_data), 32'h0);
    check("rst_s_valid", 32'(s_valid), 32'h0);
    check("rst_s_gray", 32'(s_gray), 32'h0);
    check("rst_s_count", 32'(s_count), 32'h0);
    check("rst_s_empty", 32'(s_empty), 32'h1);
    check("rst_s_ae", 32'(s_ae), 32'h1);
    check("rst_s_uf", 32'(s_uf), 32'h0);
    check("rst_s_mre", 32'(s_mre), 32'h0);
    check("rst_f_data", 32'(f_data), 32'h0);
    check("rst_f_valid", 32'(f_valid), 32'h0);
    check("rst_f_gray", 32'(f_gray), 32'h0);
    check("rst_f_count", 32'(f_count), 32'h0);
    check("rst_f_empty", 32'(f_empty), 32'h1);
    check("rst_f_ae", 32'(f_ae), 32'h1);
    check("rst_f_uf", 32'(f_uf), 32'h0);
    check("rst_f_mre", 32'(f_mre), 32'h0);
  endtask

  initial begin
    logic [4:0] ae_cnt [3];
    logic       ae_exp [3];
    ae_cnt[0] = 5'd5; ae_exp[0] = 1'b0;
    ae_cnt[1] = 5'd4; ae_exp[1] = 1'b1;
    ae_cnt[2] = 5'd3; ae_exp[2] = 1'b1;

    repeat (3) @(negedge clock);
    check_reset_state();
    reset_n = 1'b1;

    // standard mode: three words, read_enable held three clocks
    mem_s[0] = 16'h00A1; mem_s[1] = 16'h00A2; mem_s[2] = 16'h00A3;
    wp_s = 5'd3;
    @(negedge clock);
    @(negedge clock);
    check("std_empty_latency", 32'(s_empty), 32'h1);
    @(negedge clock);
    check("std_empty_fall", 32'(s_empty), 32'h0);
    check("std_count3", 32'(s_count), 32'd3);
    re_s = 1'b1;
    #1;
    check("std_mre_same_cycle", 32'(s_mre), 32'h1);
    check("std_addr0", 32'(s_addr), 32'h0);
    @(negedge clock);
    check("std_valid_k1", 32'(s_valid), 32'h0);
    check("std_count2", 32'(s_count), 32'd2);
    @(negedge clock);
    check("std_valid_k2", 32'(s_valid), 32'h1);
    check("std_data_a1", 32'(s_data), 32'h00A1);
    check("std_count1", 32'(s_count), 32'd1);
    @(negedge clock);
    re_s = 1'b0;
    check("std_data_a2", 32'(s_data), 32'h00A2);
    check("std_valid_a2", 32'(s_valid), 32'h1);
    check("std_empty_after3", 32'(s_empty), 32'h1);
    check("std_count0", 32'(s_count), 32'd0);
    @(negedge clock);
    check("std_data_a3", 32'(s_data), 32'h00A3);
    check("std_valid_a3", 32'(s_valid), 32'h1);
    @(negedge clock);
    check("std_valid_drop", 32'(s_valid), 32'h0);
    check("std_data_hold", 32'(s_data), 32'h00A3);

    // standard-mode underflow
    re_s = 1'b1;
    #1;
    check("std_uf_no_fetch", 32'(s_mre), 32'h0);
    @(negedge clock);
    re_s = 1'b0;
    check("std_uf_pulse", 32'(s_uf), 32'h1);
    check("std_uf_gray", 32'(s_gray), 32'h02);
    check("std_uf_count", 32'(s_count), 32'h0);
    check("std_uf_data", 32'(s_data), 32'h00A3);
    @(negedge clock);
    check("std_uf_one_clock", 32'(s_uf), 32'h0);

    // FWFT first word falls through
    mem_f[0] = 16'h005A;
    wp_f = 5'd1;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("fwft_fetch_m", 32'(f_mre), 32'h1);
    check("fwft_valid_m", 32'(f_valid), 32'h0);
    @(negedge clock);
    check("fwft_valid_m1", 32'(f_valid), 32'h0);
    @(negedge clock);
    check("fwft_valid_m2", 32'(f_valid), 32'h1);
    check("fwft_data_5a", 32'(f_data), 32'h005A);
    check("fwft_empty0", 32'(f_empty), 32'h0);
    check("fwft_count1", 32'(f_count), 32'd1);
    re_f = 1'b1;
    @(negedge clock);
    re_f = 1'b0;
    check("fwft_pop_valid", 32'(f_valid), 32'h0);
    check("fwft_pop_empty", 32'(f_empty), 32'h1);
    check("fwft_pop_count", 32'(f_count), 32'd0);

    // FWFT underflow
    re_f = 1'b1;
    @(negedge clock);
    re_f = 1'b0;
    check("fwft_uf_pulse", 32'(f_uf), 32'h1);
    check("fwft_uf_gray", 32'(f_gray), 32'h01);
    check("fwft_uf_data", 32'(f_data), 32'h005A);
    check("fwft_uf_count", 32'(f_count), 32'd0);
    @(negedge clock);
    check("fwft_uf_one_clock", 32'(f_uf), 32'h0);

    // full and wrap: two passes of 16 words drained at 1 word/clock
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        mem_f[wp_f[3:0]] = 16'h0100 + 16'(pass * 16 + i);
        wp_f = wp_f + 5'd1;
      end
      repeat (8) @(negedge clock);
      check($sformatf("full_count_p%0d", pass), 32'(f_count), 32'd16);
      check($sformatf("full_empty_p%0d", pass), 32'(f_empty), 32'h0);
      re_f = 1'b1;
      for (int i = 0; i < 16; i++) begin
        check($sformatf("drain_valid_p%0d_%0d", pass, i), 32'(f_valid), 32'h1);
        check($sformatf("drain_data_p%0d_%0d", pass, i), 32'(f_data), 32'h0100 + 32'(pass * 16 + i));
        @(negedge clock);
      end
      re_f = 1'b0;
      check($sformatf("drained_valid_p%0d", pass), 32'(f_valid), 32'h0);
      check($sformatf("drained_count_p%0d", pass), 32'(f_count), 32'd0);
      check($sformatf("wrap_gray_p%0d", pass), 32'(f_gray), (pass == 0) ? 32'h19 : 32'h01);
    end

    // almost_empty threshold crossing
    for (int i = 0; i < 6; i++) begin
      mem_f[wp_f[3:0]] = 16'h0200 + 16'(i);
      wp_f = wp_f + 5'd1;
    end
    repeat (6) @(negedge clock);
    check("ae_count6", 32'(f_count), 32'd6);
    check("ae_at6", 32'(f_ae), 32'h0);
    re_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("ae_count_%0d", i), 32'(f_count), 32'(ae_cnt[i]));
      check($sformatf("ae_flag_%0d", i), 32'(f_ae), 32'(ae_exp[i]));
    end
    re_f = 1'b0;

    // reset mid-stream with words still buffered
    #3;
    reset_n = 1'b0;
    re_f = 1'b1;
    wp_s = '0;
    wp_f = '0;
    #1;
    check_reset_state();
    @(negedge clock);
    check("rst_hold_mre", 32'(f_mre), 32'h0);
    re_f = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("post_rst_f_empty_%0d", i), 32'(f_empty), 32'h1);
      check($sformatf("post_rst_s_empty_%0d", i), 32'(s_empty), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
